// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults and encodings for the ram block.
//   RAM_DATA_W / RAM_ADDR_W / RAM_DEPTH : default geometry
//   RAM_INIT_FILE                        : default preload image (used only with RAM_INIT_EN)
//   RW_WRITE / RW_READ                   : data-port direction encoding
package ram_pkg;

  localparam int    RAM_DATA_W    = 32;
  localparam int    RAM_ADDR_W    = 32;
  localparam int    RAM_DEPTH     = 256;
  localparam string RAM_INIT_FILE = "ram_init.hex";

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/ram.sv
// ram: word-addressed synchronous data memory with one read/write data port
// and one read-only fetch port sharing a single address bus.
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   asynchronous active-high reset (clears DOUT/FETCH, blocks writes)
//   ADDR   in   word index shared by both ports
//   RW     in   data-port direction (0 write, 1 read)
//   DIN    in   write data
//   DOUT   out  registered data-port read result
//   FETCH  out  registered fetch-port read result
//   F      in   fetch request
//   ENABLE in   data-port enable
//
// The storage array is named `ram` so that benches can reach <inst>.ram.
module ram
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
`ifdef RAM_INIT_EN
  ,
  parameter string INIT_FILE = RAM_INIT_FILE
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              RW,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic [DATA_W-1:0] FETCH,
  input  logic              F,
  input  logic              ENABLE
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] ram [0:DEPTH-1];

  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_fetch;

  // Full-width compare so high address bits never alias onto low words.
  assign w_in_range = (ADDR < ADDR_W'(DEPTH));
  assign w_idx      = ADDR[IDX_W-1:0];

  // Equality against an unknown RW is not true, so X/Z on RW is a no-op.
  assign w_wr_en = ENABLE && (RW == RW_WRITE) && w_in_range && !RST;
  assign w_rd_en = ENABLE && (RW == RW_READ);

  // Out-of-range reads deliver zero rather than a wrapped word.
  assign w_rd_word = w_in_range ? ram[w_idx] : '0;

  // Storage is never reset; both read ports sample the pre-write word
  // (read-first) because the array update is non-blocking.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      ram[w_idx] <= DIN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dout  <= '0;
      r_fetch <= '0;
    end else begin
      if (w_rd_en) begin
        r_dout <= w_rd_word;
      end
      if (F) begin
        r_fetch <= w_rd_word;
      end
    end
  end

  assign DOUT  = r_dout;
  assign FETCH = r_fetch;

endmodule

// File: tb/tb_ram.sv
// tb_ram: directed stimulus for ram with hand-computed expected values.
module tb_ram;

  logic        CLK;
  logic        RST;
  logic [31:0] ADDR;
  logic        RW;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic [31:0] FETCH;
  logic        F;
  logic        ENABLE;

  int n_total = 0;
  int n_pass  = 0;

  ram dut (
    .CLK   (CLK),
    .RST   (RST),
    .ADDR  (ADDR),
    .RW    (RW),
    .DIN   (DIN),
    .DOUT  (DOUT),
    .FETCH (FETCH),
    .F     (F),
    .ENABLE(ENABLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit past it.
  task automatic step(input logic en, input logic rw, input logic f,
                      input logic [31:0] a, input logic [31:0] d);
    ENABLE = en;
    RW     = rw;
    F      = f;
    ADDR   = a;
    DIN    = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; ENABLE = 1'b0; RW = 1'b1; F = 1'b0; ADDR = '0; DIN = '0;
    #1;
    check("reset_dout", DOUT, 32'h0);
    check("reset_fetch", FETCH, 32'h0);
    #1;
    RST = 1'b0;

    // Write sweep 0..7
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'(i), 32'hAAAAAAA1 + 32'(i));
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sweep_ram%0d", i), dut.ram[i], 32'hAAAAAAA1 + 32'(i));
    end
    check("write_dout_hold", DOUT, 32'h0);

    // Readback then disabled hold
    step(1'b1, 1'b1, 1'b0, 32'd3, 32'h0);
    check("read_addr3", DOUT, 32'hAAAAAAA4);
    step(1'b0, 1'b1, 1'b0, 32'd4, 32'h0);
    check("disabled_dout_hold", DOUT, 32'hAAAAAAA4);

    // Fetch independent of ENABLE, then F=0 hold
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'h0);
    check("fetch_addr5", FETCH, 32'hAAAAAAA6);
    step(1'b0, 1'b1, 1'b0, 32'd6, 32'h0);
    check("fetch_hold", FETCH, 32'hAAAAAAA6);

    // Same-cycle write + fetch of address 2: read-first
    step(1'b1, 1'b0, 1'b1, 32'd2, 32'h12345678);
    check("collision_fetch_old", FETCH, 32'hAAAAAAA3);
    check("collision_dout_hold", DOUT, 32'hAAAAAAA4);
    step(1'b0, 1'b1, 1'b1, 32'd2, 32'h0);
    check("collision_fetch_new", FETCH, 32'h12345678);

    // Simultaneous data read and fetch
    step(1'b1, 1'b1, 1'b1, 32'd7, 32'h0);
    check("dual_dout", DOUT, 32'hAAAAAAA8);
    check("dual_fetch", FETCH, 32'hAAAAAAA8);

    // Disabled write
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'hAAAAAAA0);
    check("disabled_write_ram0", dut.ram[0], 32'hAAAAAAA1);

    // Top valid index
    step(1'b1, 1'b0, 1'b0, 32'd255, 32'hCAFEF00D);
    check("top_write_ram255", dut.ram[255], 32'hCAFEF00D);
    step(1'b1, 1'b1, 1'b0, 32'd255, 32'h0);
    check("top_read_dout", DOUT, 32'hCAFEF00D);

    // Out of range write: no wrap onto index 0, DOUT holds
    step(1'b1, 1'b0, 1'b0, 32'd256, 32'hFFFFFFFF);
    check("oor_write_ram0", dut.ram[0], 32'hAAAAAAA1);
    check("oor_write_ram255", dut.ram[255], 32'hCAFEF00D);
    check("oor_write_dout_hold", DOUT, 32'hCAFEF00D);
    step(1'b1, 1'b0, 1'b0, 32'h8000_0001, 32'hFFFFFFFF);
    check("oor_high_write_ram1", dut.ram[1], 32'hAAAAAAA2);

    // Out of range read returns zero on both ports
    step(1'b1, 1'b1, 1'b1, 32'd256, 32'h0);
    check("oor_read_dout", DOUT, 32'h0);
    check("oor_read_fetch", FETCH, 32'h0);

    // Load nonzero outputs, then reset mid-cycle
    step(1'b1, 1'b1, 1'b1, 32'd7, 32'h0);
    check("prereset_dout", DOUT, 32'hAAAAAAA8);
    #3;
    RST = 1'b1;
    #1;
    check("async_reset_dout", DOUT, 32'h0);
    check("async_reset_fetch", FETCH, 32'h0);

    // Write attempted while reset is held must be blocked
    step(1'b1, 1'b0, 1'b1, 32'd3, 32'h00000000);
    check("reset_blocks_write", dut.ram[3], 32'hAAAAAAA4);
    check("reset_hold_fetch", FETCH, 32'h0);

    // Release mid-cycle; first edge afterwards is a normal read
    #2;
    RST = 1'b0;
    step(1'b1, 1'b1, 1'b1, 32'd3, 32'h0);
    check("post_reset_dout", DOUT, 32'hAAAAAAA4);
    check("post_reset_fetch", FETCH, 32'hAAAAAAA4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
